// File: rtl/stall_sched_if.sv
// Signal bundle between the decode/execute pipeline control and the stall scheduler.
// The master side drives the decoded stage fields; the slave (scheduler) returns the enables.
interface stall_sched_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic        D_RsUse;
  logic        D_RtUse;
  logic [1:0]  D_TuseRs;
  logic [1:0]  D_TuseRt;
  logic        D_IsMD;
  logic [4:0]  E_A3;
  logic        E_RFWr;
  logic [1:0]  E_Tnew;
  logic [4:0]  M_A3;
  logic        M_RFWr;
  logic [1:0]  M_Tnew;
  logic        E_MDStart;
  logic        E_MDType;
  logic        PC_We;
  logic        D_We;
  logic        E_Flush;
  logic        MD_Busy;
  logic [31:0] StallCnt;

  modport master (
    output D_rs, D_rt, D_RsUse, D_RtUse, D_TuseRs, D_TuseRt, D_IsMD,
    output E_A3, E_RFWr, E_Tnew, M_A3, M_RFWr, M_Tnew, E_MDStart, E_MDType,
    input  PC_We, D_We, E_Flush, MD_Busy, StallCnt
  );

  modport slave (
    input  D_rs, D_rt, D_RsUse, D_RtUse, D_TuseRs, D_TuseRt, D_IsMD,
    input  E_A3, E_RFWr, E_Tnew, M_A3, M_RFWr, M_Tnew, E_MDStart, E_MDType,
    output PC_We, D_We, E_Flush, MD_Busy, StallCnt
  );
endinterface

// File: rtl/stall_sched.sv
// Pipeline stall scheduler: Tuse/Tnew register hazards plus a multiply/divide busy timer,
// with a saturating count of stalled cycles.
module stall_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           Clk,
  input logic           Rst,
  stall_sched_if.slave  bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]   load_val;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic               rs_hazard, rt_hazard, md_stall, stall;

  always_comb begin
    rs_hazard = bus.D_RsUse && (bus.D_rs != 5'd0) &&
                ((bus.D_rs == bus.E_A3 && bus.E_RFWr && bus.E_Tnew > bus.D_TuseRs) ||
                 (bus.D_rs == bus.M_A3 && bus.M_RFWr && bus.M_Tnew > bus.D_TuseRs));
    rt_hazard = bus.D_RtUse && (bus.D_rt != 5'd0) &&
                ((bus.D_rt == bus.E_A3 && bus.E_RFWr && bus.E_Tnew > bus.D_TuseRt) ||
                 (bus.D_rt == bus.M_A3 && bus.M_RFWr && bus.M_Tnew > bus.D_TuseRt));
    md_stall  = bus.D_IsMD && ((state_q == BUSY) || bus.E_MDStart);
    stall     = rs_hazard || rt_hazard || md_stall;
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    load_val = bus.E_MDType ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    unique case (state_q)
      IDLE: begin
        // A zero-cycle latency never enters BUSY.
        if (bus.E_MDStart && load_val != '0) begin
          state_d  = BUSY;
          md_cnt_d = load_val;
        end
      end
      BUSY: begin
        md_cnt_d = md_cnt_q - 1'b1;
        if (md_cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.PC_We    = ~stall;
  assign bus.D_We     = ~stall;
  assign bus.E_Flush  = stall;
  assign bus.MD_Busy  = (state_q == BUSY);
  assign bus.StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_sched.sv
// Directed checks of the stall scheduler: hazards, mult/div busy timing, async reset, saturation.
module tb_stall_sched;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  stall_sched_if bus ();

  stall_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.D_rs = '0; bus.D_rt = '0; bus.D_RsUse = 1'b0; bus.D_RtUse = 1'b0;
    bus.D_TuseRs = '0; bus.D_TuseRt = '0; bus.D_IsMD = 1'b0;
    bus.E_A3 = '0; bus.E_RFWr = 1'b0; bus.E_Tnew = '0;
    bus.M_A3 = '0; bus.M_RFWr = 1'b0; bus.M_Tnew = '0;
    bus.E_MDStart = 1'b0; bus.E_MDType = 1'b0;
  endtask

  task automatic set_rs_hazard();
    bus.D_rs = 5'd5; bus.D_RsUse = 1'b1; bus.D_TuseRs = 2'd0;
    bus.E_A3 = 5'd5; bus.E_RFWr = 1'b1; bus.E_Tnew = 2'd1;
  endtask

  initial begin
    clear_inputs();
    #1;
    check("rst_pc_we",   32'(bus.PC_We),   32'd1);
    check("rst_d_we",    32'(bus.D_We),    32'd1);
    check("rst_e_flush", 32'(bus.E_Flush), 32'd0);
    check("rst_md_busy", 32'(bus.MD_Busy), 32'd0);
    check("rst_stallcnt", bus.StallCnt,    32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    step();

    // E-stage rs hazard stalls and counts every cycle
    set_rs_hazard();
    #1;
    check("hz_pc_we",   32'(bus.PC_We),   32'd0);
    check("hz_d_we",    32'(bus.D_We),    32'd0);
    check("hz_e_flush", 32'(bus.E_Flush), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("hz_cnt", bus.StallCnt, 32'(i));
    end

    bus.D_rs = 5'd0; bus.E_A3 = 5'd0;
    #1;
    check("r0_pc_we",   32'(bus.PC_We),   32'd1);
    check("r0_e_flush", 32'(bus.E_Flush), 32'd0);
    step();
    check("r0_cnt", bus.StallCnt, 32'd3);
    set_rs_hazard();
    bus.E_Tnew = 2'd0;
    #1;
    check("tnew0_pc_we",   32'(bus.PC_We),   32'd1);
    check("tnew0_e_flush", 32'(bus.E_Flush), 32'd0);

    // M-stage rt hazard: Tnew > Tuse stalls, Tnew == Tuse does not
    clear_inputs();
    bus.D_rt = 5'd7; bus.D_RtUse = 1'b1; bus.D_TuseRt = 2'd1;
    bus.M_A3 = 5'd7; bus.M_RFWr = 1'b1; bus.M_Tnew = 2'd2;
    #1;
    check("mrt_stall", 32'(bus.E_Flush), 32'd1);
    bus.M_Tnew = 2'd1;
    #1;
    check("mrt_eq_nostall", 32'(bus.E_Flush), 32'd0);
    clear_inputs();
    step();

    // div start with D_IsMD held: 1 start-cycle stall + 10 busy stalls
    bus.E_MDStart = 1'b1; bus.E_MDType = 1'b1; bus.D_IsMD = 1'b1;
    #1;
    check("div_start_flush", 32'(bus.E_Flush), 32'd1);
    check("div_start_busy",  32'(bus.MD_Busy), 32'd0);
    step();
    bus.E_MDStart = 1'b0; bus.E_MDType = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("div_busy",  32'(bus.MD_Busy), 32'd1);
      check("div_pc_we", 32'(bus.PC_We),   32'd0);
      step();
    end
    check("div_done_busy",  32'(bus.MD_Busy), 32'd0);
    check("div_done_pc_we", 32'(bus.PC_We),   32'd1);
    check("div_cnt", bus.StallCnt, 32'd14);
    bus.D_IsMD = 1'b0;

    // mult start, second start during BUSY must not reload
    bus.E_MDStart = 1'b1; bus.E_MDType = 1'b0;
    step();
    bus.E_MDStart = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("mul_busy", 32'(bus.MD_Busy), 32'd1);
      if (k == 1) begin
        bus.E_MDStart = 1'b1; bus.E_MDType = 1'b1;
      end
      step();
      bus.E_MDStart = 1'b0; bus.E_MDType = 1'b0;
    end
    check("mul_done_busy", 32'(bus.MD_Busy), 32'd0);
    check("mul_cnt", bus.StallCnt, 32'd14);

    // asynchronous reset mid-div aborts busy and clears the counter
    bus.E_MDStart = 1'b1; bus.E_MDType = 1'b1; bus.D_IsMD = 1'b1;
    step();
    bus.E_MDStart = 1'b0; bus.E_MDType = 1'b0;
    step();
    step();
    check("pre_rst_busy", 32'(bus.MD_Busy), 32'd1);
    check("pre_rst_cnt", bus.StallCnt, 32'd17);
    #2 Rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.MD_Busy), 32'd0);
    check("arst_cnt",  bus.StallCnt,     32'd0);
    #1 Rst = 1'b0;
    #0;
    check("arst_pc_we", 32'(bus.PC_We), 32'd1);
    step();
    check("post_rst_busy", 32'(bus.MD_Busy), 32'd0);
    check("post_rst_cnt",  bus.StallCnt,     32'd0);
    clear_inputs();

    // saturation at all-ones
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", bus.StallCnt, 32'hFFFF_FFFE);
    set_rs_hazard();
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_cnt", bus.StallCnt, 32'hFFFF_FFFF);
    end
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/stall_sched.md
STALL_SCHED -- requirements
Module: stall_sched

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles after a mult/multu start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles after a div/divu start.
REQ-003 SHALL have one clock and an asynchronous active-high reset: Clk input 1, rising-edge clock; Rst input 1, asynchronous active-high reset.
REQ-004 SHALL have D_rs input 5, rs field of the D-stage instruction.
REQ-005 SHALL have D_rt input 5, rt field of the D-stage instruction.
REQ-006 SHALL have D_RsUse / D_RtUse input 1 each, D instruction reads rs / rt.
REQ-007 SHALL have D_TuseRs / D_TuseRt input 2 each, cycles until the operand is consumed (0 means consumed in D).
REQ-008 SHALL have D_IsMD input 1, D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 SHALL have E_A3, E_RFWr, E_Tnew (5, 1, 2), E-stage destination, write-enable and cycles-until-ready.
REQ-010 SHALL have M_A3, M_RFWr, M_Tnew (5, 1, 2), the same fields for the M stage.
REQ-011 SHALL have E_MDStart input 1, E-stage instruction starts the multiply/divide unit this cycle.
REQ-012 SHALL have E_MDType input 1, 0 = mult/multu and 1 = div/divu; valid only with E_MDStart.
REQ-013 SHALL have PC_We output 1, PC write enable.
REQ-014 SHALL have D_We output 1, D pipeline register write enable.
REQ-015 SHALL have E_Flush output 1, clears the E pipeline register (bubble insert).
REQ-016 SHALL have MD_Busy output 1, multiply/divide unit busy.
REQ-017 SHALL have StallCnt output 32, count of stalled cycles since reset.

Function
REQ-018 SHALL compute rs hazard = D_RsUse & (D_rs!=0) & ((D_rs==E_A3 & E_RFWr & E_Tnew>D_TuseRs) | (D_rs==M_A3 & M_RFWr & M_Tnew>D_TuseRs)).
REQ-019 SHALL compute rt hazard identically, using D_rt, D_RtUse and D_TuseRt.
REQ-020 SHALL compute MD stall = D_IsMD & (MD_Busy | E_MDStart).
REQ-021 SHALL define Stall = rs hazard | rt hazard | MD stall, combinational from the current inputs and registered state.
REQ-022 SHALL drive PC_We = ~Stall, D_We = ~Stall and E_Flush = Stall in the same cycle, with no added latency.
REQ-023 SHALL use a two-state FSM: IDLE and BUSY, with MD_Busy = (state==BUSY).
REQ-024 SHALL, in IDLE with E_MDStart=1 at a rising edge, load the down-counter with MULT_CYCLES (E_MDType=0) or DIV_CYCLES (E_MDType=1) and enter BUSY.
REQ-025 SHALL, in BUSY, decrement the counter each edge and return to IDLE on the edge where the counter goes 1->0, so MD_Busy is high for exactly N cycles after the start edge.
REQ-026 SHALL ignore E_MDStart in BUSY: no reload and no state change.
REQ-027 SHALL size the counter to hold max(MULT_CYCLES, DIV_CYCLES); a parameter value of 0 SHALL leave the FSM in IDLE.
REQ-028 SHALL increment StallCnt by 1 on every rising edge with Stall=1, saturating at 32'hFFFFFFFF with no wrap to 0.
REQ-029 SHALL allow simultaneous hazard and MD stall; these SHALL count once per cycle in StallCnt.

Reset
REQ-030 SHALL, while Rst=1, immediately (asynchronously) force state=IDLE, counter=0, MD_Busy=0 and StallCnt=0.
REQ-031 SHALL, on Rst asserted mid-BUSY, abort the busy period; no stall SHALL persist after release unless a combinational hazard is present.
REQ-032 SHALL make PC_We, D_We and E_Flush during reset purely combinational from the inputs; with all inputs 0 they SHALL be 1, 1, 0.

Verification
REQ-033 SHALL be verified with: D_rs=5, D_RsUse=1, D_TuseRs=0, E_A3=5, E_RFWr=1, E_Tnew=1 -> PC_We=0, D_We=0, E_Flush=1, StallCnt +1 per cycle.
REQ-034 SHALL be verified with: the same hazard but D_rs=0, or E_Tnew=0 -> PC_We=1, E_Flush=0.
REQ-035 SHALL be verified with: E_MDStart=1, E_MDType=1 for one cycle, then D_IsMD=1 held -> MD_Busy=1 for exactly 10 cycles, Stall=1 for 11 cycles including the start cycle, then PC_We=1.
REQ-036 SHALL be verified with: a mult start, then a second E_MDStart during BUSY -> MD_Busy falls 5 cycles after the first start, with no reload.
REQ-037 SHALL be verified with: Rst pulsed asynchronously (mid-cycle) at busy cycle 3 of a div -> MD_Busy=0 and StallCnt=0 before the next edge.
REQ-038 SHALL be verified with: StallCnt preloaded near saturation by forcing 0xFFFFFFFE, with Stall held for 3 cycles -> StallCnt holds 0xFFFFFFFF.
